int_memory_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 6×4-bit `int_memory` register file. It accepts independent read/write requests from two requesters (A, B) and grants one per transaction. It drives the memory's ADR/DI/EN/WR pins with glitch-free timing and returns read data or an error response. It sits between the core's two memory clients and a single `int_memory` instance.

---
 rtl/int_memory_arbiter_pkg.sv | 32 +++
 rtl/int_mem_arb_pick.sv | 46 ++++
 rtl/int_memory_arbiter.sv | 138 +++++++++++++
 tb/tb_int_memory_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_memory_arbiter_pkg.sv
// Shared types and constants for the int_memory two-port arbiter.
package int_memory_arbiter_pkg;

    localparam int ADR_W  = 3;
    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    // Latched transaction: who asked, what, and whether the address is bogus.
    typedef struct packed {
        req_id_e             id;
        logic                we;
        logic                oor;
        logic [ADR_W-1:0]    adr;
        logic [DATA_W-1:0]   wdata;
    } cmd_t;

    // True when the address lies beyond the implemented words.
    function automatic logic adr_oor(input logic [ADR_W-1:0] adr, input int unsigned nwords);
        return {{(32-ADR_W){1'b0}}, adr} >= nwords;
    endfunction

endpackage

// File: rtl/int_mem_arb_pick.sv
// Winner selection between requesters A and B.
// With INT_MEM_ARB_RR_EN defined a 1-bit pointer alternates priority after
// every grant; otherwise A always wins a conflict and no pointer exists.
module int_mem_arb_pick
    import int_memory_arbiter_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    a_req_i,
    input  logic    b_req_i,
    input  logic    grant_i,
    output req_id_e winner_o
);

`ifdef INT_MEM_ARB_RR_EN
    req_id_e ptr_q, ptr_d;

    // On conflict the pointer names the winner; a lone request always wins.
    always_comb begin
        winner_o = REQ_A;
        if (a_req_i && b_req_i) winner_o = ptr_q;
        else if (b_req_i)       winner_o = REQ_B;
    end

    // After each grant, hand priority to the requester that was not served.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_i) ptr_d = (winner_o == REQ_A) ? REQ_B : REQ_A;
    end

    // Pointer register, A preferred out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= REQ_A;
        else         ptr_q <= ptr_d;
    end
`else
    logic unused_fixed;
    assign unused_fixed = clk_i ^ rst_ni ^ grant_i;

    // Fixed priority: A unless only B is asking.
    always_comb begin
        winner_o = (a_req_i || !b_req_i) ? REQ_A : REQ_B;
    end
`endif

endmodule

// File: rtl/int_memory_arbiter.sv
// Two-port arbiter/sequencer for the 6x4-bit int_memory.
// IDLE -> ACCESS -> RESP, one transaction every three cycles. Memory pins are
// launched on the falling clock edge so the memory's EN&CLK gated clock never
// sees a runt pulse. Define INT_MEM_ARB_RR_EN for round-robin arbitration.
module int_memory_arbiter
    import int_memory_arbiter_pkg::*;
#(
    parameter int unsigned NWORDS = 6
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              A_REQ,
    input  logic              A_WE,
    input  logic [ADR_W-1:0]  A_ADR,
    input  logic [DATA_W-1:0] A_WDATA,
    input  logic              B_REQ,
    input  logic              B_WE,
    input  logic [ADR_W-1:0]  B_ADR,
    input  logic [DATA_W-1:0] B_WDATA,
    output logic              A_GNT,
    output logic              B_GNT,
    output logic              A_ACK,
    output logic              B_ACK,
    output logic              ERR,
    output logic [DATA_W-1:0] RDATA,
    output logic [ADR_W-1:0]  MEM_ADR,
    output logic [DATA_W-1:0] MEM_DI,
    output logic              MEM_EN,
    output logic              MEM_WR,
    input  logic [DATA_W-1:0] MEM_DO
);

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADR_W-1:0]  mem_adr_q, mem_adr_d;
    logic [DATA_W-1:0] mem_di_q, mem_di_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_wr_q, mem_wr_d;
    req_id_e           win;
    logic              take;

    assign take = (state_q == ST_IDLE) && (A_REQ || B_REQ);

    int_mem_arb_pick u_pick (
        .clk_i    (CLK),
        .rst_ni   (RST_N),
        .a_req_i  (A_REQ),
        .b_req_i  (B_REQ),
        .grant_i  (take),
        .winner_o (win)
    );

    // Sequencer: latch the winner's command, then capture read data, then a guard cycle.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d = ST_ACCESS;
                    cmd_d.id = win;
                    if (win == REQ_B) begin
                        cmd_d.we    = B_WE;
                        cmd_d.adr   = B_ADR;
                        cmd_d.wdata = B_WDATA;
                    end else begin
                        cmd_d.we    = A_WE;
                        cmd_d.adr   = A_ADR;
                        cmd_d.wdata = A_WDATA;
                    end
                    cmd_d.oor = adr_oor(cmd_d.adr, NWORDS);
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                if (!cmd_q.we) rdata_d = cmd_q.oor ? '0 : MEM_DO;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, command and read-data registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory pins follow the command during ACCESS; elsewhere EN/WR drop and ADR/DI hold.
    always_comb begin
        mem_adr_d = mem_adr_q;
        mem_di_d  = mem_di_q;
        mem_en_d  = 1'b0;
        mem_wr_d  = 1'b0;
        if (state_q == ST_ACCESS) begin
            mem_adr_d = cmd_q.adr;
            mem_di_d  = cmd_q.wdata;
            mem_en_d  = !cmd_q.oor;
            mem_wr_d  = cmd_q.we && !cmd_q.oor;
        end
    end

    // Falling-edge launch keeps EN stable across the whole high phase of CLK.
    always_ff @(negedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem_adr_q <= '0;
            mem_di_q  <= '0;
            mem_en_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
        end else begin
            mem_adr_q <= mem_adr_d;
            mem_di_q  <= mem_di_d;
            mem_en_q  <= mem_en_d;
            mem_wr_q  <= mem_wr_d;
        end
    end

    assign A_GNT   = (state_q == ST_ACCESS) && (cmd_q.id == REQ_A);
    assign B_GNT   = (state_q == ST_ACCESS) && (cmd_q.id == REQ_B);
    assign A_ACK   = (state_q == ST_RESP)   && (cmd_q.id == REQ_A);
    assign B_ACK   = (state_q == ST_RESP)   && (cmd_q.id == REQ_B);
    assign ERR     = (state_q == ST_RESP)   && cmd_q.oor;
    assign RDATA   = rdata_q;
    assign MEM_ADR = mem_adr_q;
    assign MEM_DI  = mem_di_q;
    assign MEM_EN  = mem_en_q;
    assign MEM_WR  = mem_wr_q;

endmodule

// File: tb/tb_int_memory_arbiter.sv
// Scoreboard bench for int_memory_arbiter with a behavioural int_memory model.
module tb_int_memory_arbiter;

    logic       CLK = 1'b0, RST_N = 1'b0;
    logic       A_REQ = 1'b0, A_WE = 1'b0, B_REQ = 1'b0, B_WE = 1'b0;
    logic [2:0] A_ADR = 3'd0, B_ADR = 3'd0;
    logic [3:0] A_WDATA = 4'd0, B_WDATA = 4'd0;
    logic       A_GNT, B_GNT, A_ACK, B_ACK, ERR, MEM_EN, MEM_WR;
    logic [3:0] RDATA, MEM_DI, MEM_DO;
    logic [2:0] MEM_ADR;

    typedef struct {
        logic       id;
        logic       rd;
        logic       err;
        logic [3:0] d;
        logic [3:0] alt;
    } exp_t;

    exp_t       sbq[$];
    exp_t       mon_e;
    int         checks = 0, errors = 0, cyc = 0, glitch = 0, en_rise = 0;
    logic [3:0] mem     [0:5];
    logic [3:0] ref_mem [0:5];
    logic       alt_en = 1'b0;
    logic [3:0] alt_val = 4'd0;

    int_memory_arbiter #(.NWORDS(6)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_ADR(A_ADR), .A_WDATA(A_WDATA),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADR(B_ADR), .B_WDATA(B_WDATA),
        .A_GNT(A_GNT), .B_GNT(B_GNT), .A_ACK(A_ACK), .B_ACK(B_ACK),
        .ERR(ERR), .RDATA(RDATA),
        .MEM_ADR(MEM_ADR), .MEM_DI(MEM_DI), .MEM_EN(MEM_EN), .MEM_WR(MEM_WR),
        .MEM_DO(MEM_DO)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // int_memory: write on the gated clock, asynchronous read
    initial for (int i = 0; i < 6; i++) begin mem[i] = 4'd0; ref_mem[i] = 4'd0; end
    always @(posedge CLK) if (MEM_EN && MEM_WR && MEM_ADR < 3'd6) mem[MEM_ADR] <= MEM_DI;
    assign MEM_DO = (MEM_ADR < 3'd6) ? mem[MEM_ADR] : 4'd0;

    // memory pins may only move while CLK is low (or under reset)
    always @(MEM_EN or MEM_WR or MEM_ADR or MEM_DI)
        if (CLK === 1'b1 && RST_N === 1'b1) glitch++;
    always @(posedge MEM_EN) en_rise++;

    // scoreboard consumer
    always begin
        @(negedge CLK); #1;
        if (A_ACK === 1'b1 || B_ACK === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got A_ACK=%b B_ACK=%b, expected none", A_ACK, B_ACK);
            end else begin
                mon_e = sbq.pop_front();
                if (A_ACK !== !mon_e.id || B_ACK !== mon_e.id) begin
                    errors++;
                    $display("FAIL ack_id: got A=%b B=%b, expected id %0d", A_ACK, B_ACK, mon_e.id);
                end
                checks++;
                if (ERR !== mon_e.err) begin
                    errors++;
                    $display("FAIL ack_err: got %b, expected %b", ERR, mon_e.err);
                end
                if (mon_e.rd) begin
                    checks++;
                    if (RDATA !== mon_e.d && RDATA !== mon_e.alt) begin
                        errors++;
                        $display("FAIL rdata: got %h, expected %h (or %h)", RDATA, mon_e.d, mon_e.alt);
                    end
                end
            end
        end
    end

    // one transaction on requester id; pushes the expectation and reports what was seen
    task automatic txn(input logic id, input logic we, input logic [2:0] adr, input logic [3:0] wd,
                       output bit got, output int gcyc, output logic en_g, output logic wr_g,
                       output logic ack_a, output logic en_a);
        exp_t e;
        e.id = id; e.rd = !we; e.err = (adr >= 3'd6); e.d = 4'd0;
        if (!e.err) e.d = ref_mem[adr];
        e.alt = alt_en ? alt_val : e.d;
        alt_en = 1'b0;
        if (we && !e.err) ref_mem[adr] = wd;
        sbq.push_back(e);
        if (id) begin B_REQ = 1'b1; B_WE = we; B_ADR = adr; B_WDATA = wd; end
        else    begin A_REQ = 1'b1; A_WE = we; A_ADR = adr; A_WDATA = wd; end
        got = 0; gcyc = 0; en_g = 0; wr_g = 0; ack_a = 0; en_a = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge CLK); #1;
            if ((id ? B_GNT : A_GNT) === 1'b1) got = 1;
        end
        if (got) begin
            gcyc = cyc; en_g = MEM_EN; wr_g = MEM_WR;
            @(negedge CLK); #1;
            ack_a = id ? B_ACK : A_ACK; en_a = MEM_EN;
        end
        if (id) B_REQ = 1'b0; else A_REQ = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        checks++;
        if ({A_GNT, B_GNT, A_ACK, B_ACK, ERR} !== 5'b0) begin
            errors++; $display("FAIL reset_hs: got %b, expected 00000", {A_GNT, B_GNT, A_ACK, B_ACK, ERR});
        end
        checks++;
        if (RDATA !== 4'd0) begin errors++; $display("FAIL reset_rdata: got %h, expected 0", RDATA); end
        checks++;
        if ({MEM_EN, MEM_WR, MEM_ADR, MEM_DI} !== 9'd0) begin
            errors++; $display("FAIL reset_mem: got %h, expected 0", {MEM_EN, MEM_WR, MEM_ADR, MEM_DI});
        end
        RST_N = 1'b1;
        @(negedge CLK); #1;
    endtask

    task automatic test_conflict();
        logic ord [0:4];
        int   n;
        bit   got, last;
`ifdef INT_MEM_ARB_RR_EN
        n = 4; ord[0] = 0; ord[1] = 1; ord[2] = 0; ord[3] = 1; ord[4] = 0;
`else
        n = 5; ord[0] = 0; ord[1] = 0; ord[2] = 0; ord[3] = 0; ord[4] = 1;
`endif
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.id = ord[k]; e.rd = 1'b1; e.err = 1'b0;
            e.d = ord[k] ? ref_mem[4] : ref_mem[1]; e.alt = e.d;
            sbq.push_back(e);
        end
        A_WE = 1'b0; B_WE = 1'b0; A_ADR = 3'd1; B_ADR = 3'd4;
        A_REQ = 1'b1; B_REQ = 1'b1;
        for (int k = 0; k < n; k++) begin
            got = 0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(negedge CLK); #1;
                if (A_GNT === 1'b1 || B_GNT === 1'b1) got = 1;
            end
            checks++;
            if (!(got && A_GNT === !ord[k] && B_GNT === ord[k])) begin
                errors++;
                $display("FAIL conflict_order[%0d]: got A_GNT=%b B_GNT=%b, expected winner %0d", k, A_GNT, B_GNT, ord[k]);
            end
            if (!got) begin A_REQ = 1'b0; B_REQ = 1'b0; sbq.delete(); break; end
            @(negedge CLK); #1;
            last = 1;
            for (int j = k + 1; j < n; j++) if (ord[j] == ord[k]) last = 0;
            if (last) begin if (ord[k]) B_REQ = 1'b0; else A_REQ = 1'b0; end
        end
        A_REQ = 1'b0; B_REQ = 1'b0;
        repeat (2) @(negedge CLK); #1;
    endtask

    task automatic test_write_read();
        bit got; int g, c0; logic eg, wg, aa, ea;
        c0 = cyc;
        txn(1'b0, 1'b1, 3'd2, 4'hA, got, g, eg, wg, aa, ea);
        checks++;
        if (!got || g !== c0 + 1) begin errors++; $display("FAIL wr_gnt: got cycle %0d, expected %0d", g, c0 + 1); end
        checks++;
        if ({eg, wg, aa, ea} !== 4'b1110) begin
            errors++; $display("FAIL wr_timing: got en/wr/ack/en_after=%b, expected 1110", {eg, wg, aa, ea});
        end
        checks++;
        if (mem[2] !== 4'hA) begin errors++; $display("FAIL wr_mem: got %h, expected a", mem[2]); end
        txn(1'b0, 1'b0, 3'd2, 4'h0, got, g, eg, wg, aa, ea);
        checks++;
        if (!got || {eg, wg, aa} !== 3'b101) begin
            errors++; $display("FAIL rd_timing: got en/wr/ack=%b, expected 101", {eg, wg, aa});
        end
    endtask

    task automatic test_out_of_range();
        bit got; int g, r0; logic eg, wg, aa, ea;
        txn(1'b1, 1'b0, 3'd2, 4'h0, got, g, eg, wg, aa, ea);
        r0 = en_rise;
        txn(1'b1, 1'b0, 3'd6, 4'h0, got, g, eg, wg, aa, ea);
        checks++;
        if (!got || aa !== 1'b1) begin errors++; $display("FAIL oor_rd_ack: got %b, expected 1", aa); end
        txn(1'b1, 1'b1, 3'd7, 4'h3, got, g, eg, wg, aa, ea);
        checks++;
        if (!got || aa !== 1'b1) begin errors++; $display("FAIL oor_wr_ack: got %b, expected 1", aa); end
        checks++;
        if (en_rise !== r0) begin errors++; $display("FAIL oor_en: got %0d EN pulses, expected 0", en_rise - r0); end
        for (int a = 0; a < 6; a++) txn(1'b0, 1'b0, a[2:0], 4'h0, got, g, eg, wg, aa, ea);
    endtask

    task automatic test_back_to_back();
        bit got; int g, gp; logic eg, wg, aa, ea;
        gp = 0;
        for (int a = 0; a < 6; a++) begin
            txn(1'b0, 1'b1, a[2:0], 4'h5, got, g, eg, wg, aa, ea);
            if (a > 0) begin
                checks++;
                if (!got || g - gp != 3) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d, expected 3", a, g - gp); end
            end
            gp = g;
        end
        for (int a = 0; a < 6; a++) txn(1'b1, 1'b0, a[2:0], 4'h0, got, g, eg, wg, aa, ea);
        txn(1'b0, 1'b1, 3'd0, 4'hF, got, g, eg, wg, aa, ea);
        for (int a = 0; a < 6; a++) txn(1'b1, 1'b0, a[2:0], 4'h0, got, g, eg, wg, aa, ea);
    endtask

    task automatic test_reset_mid();
        bit got; int g, r0; logic eg, wg, aa, ea;
        txn(1'b0, 1'b1, 3'd3, 4'h1, got, g, eg, wg, aa, ea);
        txn(1'b0, 1'b0, 3'd3, 4'h0, got, g, eg, wg, aa, ea);
        A_REQ = 1'b1; A_WE = 1'b1; A_ADR = 3'd3; A_WDATA = 4'h9;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge CLK); #1;
            if (A_GNT === 1'b1) got = 1;
        end
        checks++;
        if (!got || MEM_EN !== 1'b1) begin errors++; $display("FAIL mid_access: got gnt=%b en=%b, expected 1 1", got, MEM_EN); end
        RST_N = 1'b0;
        A_REQ = 1'b0;
        r0 = en_rise;
        #1;
        checks++;
        if ({A_GNT, B_GNT, A_ACK, B_ACK, ERR, RDATA} !== 9'd0) begin
            errors++; $display("FAIL mid_rst_out: got %h, expected 0", {A_GNT, B_GNT, A_ACK, B_ACK, ERR, RDATA});
        end
        checks++;
        if ({MEM_EN, MEM_WR, MEM_ADR, MEM_DI} !== 9'd0) begin
            errors++; $display("FAIL mid_rst_mem: got %h, expected 0", {MEM_EN, MEM_WR, MEM_ADR, MEM_DI});
        end
        repeat (3) @(negedge CLK);
        #1;
        checks++;
        if (en_rise !== r0 || MEM_EN !== 1'b0) begin errors++; $display("FAIL mid_rst_en: got en=%b, expected 0", MEM_EN); end
        RST_N = 1'b1;
        @(negedge CLK); #1;
        ref_mem[3] = 4'h1; alt_en = 1'b1; alt_val = 4'h9;
        txn(1'b0, 1'b0, 3'd3, 4'h0, got, g, eg, wg, aa, ea);
        ref_mem[3] = mem[3];
        checks++;
        if (!got || aa !== 1'b1) begin errors++; $display("FAIL post_rst_rd: got ack %b, expected 1", aa); end
    endtask

    initial begin
        test_reset();
        test_conflict();
        test_write_read();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge CLK);
        checks++;
        if (sbq.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending, expected 0", sbq.size()); end
        checks++;
        if (glitch != 0) begin errors++; $display("FAIL mem_glitch: got %0d posedge-phase changes, expected 0", glitch); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
